// File: rtl/clock_pkg.sv
// Shared BCD field limits and helpers for the time-of-day counter.
// All fields are packed BCD {tens, ones}.
package clock_pkg;
    localparam int         BCD_W        = 8;
    localparam logic [7:0] SEC_MAX      = 8'h59;
    localparam logic [7:0] MIN_MAX      = 8'h59;
    localparam logic [7:0] HOUR_MAX     = 8'h23;
    localparam logic [7:0] NOON         = 8'h12;
    localparam logic [7:0] H12_MIDNIGHT = 8'h12;

    // Both digits must be decimal before the field is compared against its limit.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic logic [7:0] bcd_fix(input logic [7:0] v, input logic [7:0] max);
        return bcd_ok(v, max) ? v : 8'h00;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'h0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 24-hour BCD hour to 12-hour display: 00 -> 12, 13..23 -> 01..11.
    function automatic logic [7:0] to_12h(input logic [7:0] h);
        logic [7:0] r;
        r = h;
        if (h == 8'h00)
            r = H12_MIDNIGHT;
        else if (h > NOON) begin
            if (h[7:4] == 4'h1)
                r = {4'h0, h[3:0] - 4'd2};
            else if (h[3:0] < 4'd2)
                r = {4'h0, h[3:0] + 4'd8};
            else
                r = {4'h1, h[3:0] - 4'd2};
        end
        return r;
    endfunction
endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX, with synchronous load and
// clear-on-tick of any illegal held value.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_cin,
    input  logic       i_ld,
    input  logic [7:0] i_ld_val,
    output logic [7:0] o_q,
    output logic       o_cout
);
    logic [7:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_q <= 8'h00;
        else if (i_ld)
            r_q <= bcd_fix(i_ld_val, MAX);
        else if (i_tick) begin
            // Illegal contents are scrubbed on any tick, even without carry-in.
            if (!bcd_ok(r_q, MAX))
                r_q <= 8'h00;
            else if (i_cin)
                r_q <= (r_q == MAX) ? 8'h00 : bcd_inc(r_q);
        end
    end

    assign o_q    = r_q;
    assign o_cout = i_tick & i_cin & (r_q == MAX);
endmodule

// File: rtl/bcd_time_counter.sv
// Prescaled 24-hour BCD clock with 12-hour display, preset load,
// day-carry pulse and an optional hour:minute alarm.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter bit ALARM_EN = 1
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       EN,
    input  logic       Mode12,
    input  logic       Load,
    input  logic [7:0] LdH,
    input  logic [7:0] LdM,
    input  logic [7:0] LdS,
    input  logic       AlarmWr,
    input  logic [7:0] AlmH,
    input  logic [7:0] AlmM,
    input  logic       AlarmOn,
    output logic [7:0] Hour,
    output logic [7:0] Min,
    output logic [7:0] Sec,
    output logic       PM,
    output logic       DayCarry,
    output logic       Alarm
);
    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [15:0] r_pre;
    logic [7:0]  r_hour;
    logic        r_dc;
    logic [7:0]  w_sec, w_min;
    logic        w_tick, w_sec_co, w_min_co;

    // Load outranks the tick, so a tick is never seen on a load edge.
    assign w_tick = EN & ~Load & (r_pre == PS_LAST);

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR)
            r_pre <= 16'd0;
        else if (Load || w_tick)
            r_pre <= 16'd0;
        else if (EN)
            r_pre <= r_pre + 16'd1;
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .i_clk(CP), .i_rst_n(nCR), .i_tick(w_tick), .i_cin(w_tick),
        .i_ld(Load), .i_ld_val(LdS), .o_q(w_sec), .o_cout(w_sec_co)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .i_clk(CP), .i_rst_n(nCR), .i_tick(w_tick), .i_cin(w_sec_co),
        .i_ld(Load), .i_ld_val(LdM), .o_q(w_min), .o_cout(w_min_co)
    );

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            r_hour <= 8'h00;
            r_dc   <= 1'b0;
        end else begin
            r_dc <= w_min_co & (r_hour == HOUR_MAX);
            if (Load)
                r_hour <= bcd_fix(LdH, HOUR_MAX);
            else if (w_tick) begin
                if (!bcd_ok(r_hour, HOUR_MAX))
                    r_hour <= 8'h00;
                else if (w_min_co)
                    r_hour <= (r_hour == HOUR_MAX) ? 8'h00 : bcd_inc(r_hour);
            end
        end
    end

    generate
        if (ALARM_EN) begin : g_alarm
            logic [7:0] r_alm_h, r_alm_m;
            logic       r_on_d;

            always_ff @(posedge CP or negedge nCR) begin
                if (!nCR) begin
                    r_alm_h <= 8'h00;
                    r_alm_m <= 8'h00;
                    r_on_d  <= 1'b0;
                end else begin
                    if (AlarmWr) begin
                        r_alm_h <= bcd_fix(AlmH, HOUR_MAX);
                        r_alm_m <= bcd_fix(AlmM, MIN_MAX);
                    end
                    r_on_d <= w_tick & AlarmOn;
                end
            end

            // Qualified by the previous edge being a tick, so a load onto the alarm time stays silent.
            assign Alarm = r_on_d & (r_hour == r_alm_h) & (w_min == r_alm_m) & (w_sec == 8'h00);
        end else begin : g_no_alarm
            assign Alarm = 1'b0;
        end
    endgenerate

    assign Hour     = Mode12 ? to_12h(r_hour) : r_hour;
    assign Min      = w_min;
    assign Sec      = w_sec;
    assign PM       = (r_hour >= NOON);
    assign DayCarry = r_dc;
endmodule

// File: doc/bcd_time_counter.md
BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 SHALL have parameter PRESCALE, default 1: number of enabled CP edges per time tick (1..65535).
REQ-002 SHALL have parameter ALARM_EN, default 1: 1 = alarm logic present; 0 = Alarm tied 0, alarm registers removed.
REQ-003 SHALL have port CP  input  1  clock, all state on rising edge.
REQ-004 SHALL have port nCR  input  1  asynchronous active-low clear.
REQ-005 SHALL have port EN  input  1  count enable; 0 freezes prescaler and time.
REQ-006 SHALL have port Mode12  input  1  display mode: 1 = 12-hour, 0 = 24-hour.
REQ-007 SHALL have port Load  input  1  synchronous time preset strobe.
REQ-008 SHALL have port LdH, LdM, LdS  input  8 each  preset hour/minute/second, packed BCD, always 24-hour.
REQ-009 SHALL have port AlarmWr  input  1  synchronous alarm-time write strobe.
REQ-010 SHALL have port AlmH, AlmM  input  8 each  alarm hour/minute, packed BCD, 24-hour.
REQ-011 SHALL have port AlarmOn  input  1  alarm output enable.
REQ-012 SHALL have port Hour, Min, Sec  output  8 each  current time, packed BCD {tens,ones}.
REQ-013 SHALL have port PM  output  1  1 when internal hour >= 12 (valid in both modes).
REQ-014 SHALL have port DayCarry  output  1  one-CP pulse on 23:59:59 -> 00:00:00.
REQ-015 SHALL have port Alarm  output  1  one-CP pulse on alarm match.

Function
REQ-016 Tick: prescaler SHALL count CP edges with EN=1, 0..PRESCALE-1; tick asserted on the edge where prescaler = PRESCALE-1, prescaler then wraps to 0.
REQ-017 With PRESCALE=1 every CP edge with EN=1 SHALL be a tick.
REQ-018 Seconds SHALL count 00..59 BCD per tick; 59 -> 00 generates minute carry.
REQ-019 Minutes SHALL count 00..59 BCD on minute carry; 59 -> 00 generates hour carry.
REQ-020 Internal hour SHALL count 00..23 BCD on hour carry; 23 -> 00 asserts DayCarry for exactly the next CP cycle.
REQ-021 Ones digit 9 -> 0 SHALL increment tens digit in the same edge (e.g. 09 -> 10, 19 -> 20).
REQ-022 Hour output SHALL be combinational from state: Mode12=0 -> internal hour; Mode12=1 -> 00 -> 12, 01..12 unchanged, 13..23 -> 01..11.
REQ-023 Toggling Mode12 SHALL NOT alter internal state; Hour output changes in the same cycle.
REQ-024 Load=1 SHALL update time on the next edge regardless of EN and reset prescaler to 0; Load has priority over tick.
REQ-025 Any preset field out of range (a digit > 9, seconds/minutes > 59, hour > 23) SHALL load as 00; valid fields load unchanged.
REQ-026 If an internal field ever holds an illegal value, the next tick SHALL clear that field to 00 without generating carry.
REQ-027 AlarmWr=1 SHALL register AlmH/AlmM on the next edge with the same range correction as REQ-025; AlarmWr and Load in one cycle both take effect.
REQ-028 Alarm SHALL pulse for one CP cycle after a tick that makes the time equal to alarm hour:minute:00, only if AlarmOn=1 at that tick.
REQ-029 Load landing on the alarm time SHALL NOT raise Alarm; DayCarry SHALL NOT pulse on Load.
REQ-030 EN=0 SHALL hold prescaler and time; Load and AlarmWr remain active.

Reset
REQ-031 nCR=0 SHALL immediately clear time to 00:00:00, prescaler to 0, alarm time to 00:00, and DayCarry and Alarm to 0; Hour reads 12 in 12-hour mode.
REQ-032 Reset asserted mid-tick or mid-load SHALL override; first tick after release SHALL occur PRESCALE enabled edges later.

Structure
REQ-033 Shared package clock_pkg SHALL hold BCD field width (8), limits 8'h59 and 8'h23, and the 12-hour noon/midnight constants.
REQ-034 One sub-module bcd_mod_counter (parametrised BCD modulus, carry-in, carry-out, load, illegal-value clear) SHALL implement seconds and minutes; hour logic and 12-hour conversion stay in the top.

Verification
REQ-035 PRESCALE=1, EN=1 from reset: after 86400 edges time = 00:00:00 and DayCarry has pulsed once, on the final edge.
REQ-036 Load 11:59:59, Mode12=1: Hour=11, PM=0; one tick -> Hour=12, PM=1; Mode12=0 -> Hour=12.
REQ-037 Load 0x7A:0x60:0x30 -> time 00:00:30; force illegal minute via Load 12:5A:59 -> minute loads 00.
REQ-038 PRESCALE=4: EN toggled 1,0,1,1,1 -> seconds increment only on the 4th enabled edge.
REQ-039 AlarmWr 06:30, AlarmOn=1, Load 06:29:59, one tick -> Alarm one-cycle pulse; repeat with AlarmOn=0 -> no pulse; Load 06:30:00 -> no pulse.
REQ-040 nCR pulsed low between edges while running at 23:59:59 -> outputs 00:00:00 immediately, no DayCarry.
